// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the fetch/data memory port arbiter.
//               owner_t  - who issued an in-flight memory access
//               tag_t    - per-access bookkeeping carried from issue to return
//               TAG_NONE - empty pipeline slot
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;    // requester that issued the access
        logic   is_read;  // 0 for stores: no response is produced
        logic   killed;   // fetch squashed by a taken branch
    } tag_t;

    localparam tag_t TAG_NONE = '{owner: OWN_NONE, is_read: 1'b0, killed: 1'b0};

    // A fetch tag that a flush this cycle must squash.
    function automatic tag_t kill_if_fetch(input tag_t t, input logic flush);
        tag_t r;
        r = t;
        if (flush && (t.owner == OWN_IF)) begin
            r.killed = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : arb_tag_pipe
// Description : Two-stage tag shift register that follows every granted
//               access from the issue cycle to the cycle its read data
//               appears on mem_rdata. A flush marks every fetch tag present
//               in the pipe (including the one being issued and the one
//               returning right now) as killed. Data tags are untouched.
// Ports       : clk       - clock
//               reset     - synchronous active-high, clears both stages
//               flush     - taken branch, kills in-flight fetches
//               issue_tag - tag of the access granted this cycle
//                           (TAG_NONE when nothing is granted)
//               ret_tag   - tag of the access whose data is on mem_rdata
//                           this cycle, with this cycle's flush applied
// Revision    : 1.0 - initial release
// ============================================================================
module arb_tag_pipe
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  tag_t issue_tag,
    output tag_t ret_tag
);

    // r_stage1: access on the mem_* bus this cycle
    // r_stage2: access whose read data is on mem_rdata this cycle
    tag_t r_stage1;
    tag_t r_stage2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage1 <= TAG_NONE;
            r_stage2 <= TAG_NONE;
        end else begin
            r_stage1 <= kill_if_fetch(issue_tag, flush);
            r_stage2 <= kill_if_fetch(r_stage1, flush);
        end
    end

    // The returning fetch is squashed combinationally when the flush lands
    // in the same cycle as its data.
    assign ret_tag = kill_if_fetch(r_stage2, flush);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported synchronous-read memory between the
//               instruction fetch port (if_*) and the data port (dm_*).
//               One grant per cycle; data wins contention until it has won
//               MAX_DATA_STREAK times in a row while a fetch waited, then the
//               fetch is granted. Granted accesses appear on mem_* one cycle
//               later; read data returns the cycle after that and is routed
//               to its owner by a tag pipeline.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               flush                 - taken branch, kills in-flight fetches
//               if_req/if_addr        - fetch request
//               if_ready              - fetch accepted this cycle
//               if_rvalid/if_rdata    - fetch response
//               dm_req/dm_we/dm_addr/dm_wdata - load/store request
//               dm_ready              - data request accepted this cycle
//               dm_rvalid/dm_rdata    - load response
//               mem_en/mem_we/mem_addr/mem_wdata - registered memory command
//               mem_rdata             - memory read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                c_CNT_W      = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [c_CNT_W-1:0] c_STREAK_MAX = c_CNT_W'(MAX_DATA_STREAK);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_streak;
    logic               w_streak_full;
    logic               w_if_grant;
    logic               w_dm_grant;

    assign w_streak_full = (r_streak == c_STREAK_MAX);

    // Data has priority; a waiting fetch takes over once data has used up
    // its streak allowance. Both grants are forced low during reset.
    assign w_dm_grant = !reset && dm_req && !(if_req && w_streak_full);
    assign w_if_grant = !reset && if_req && (!dm_req || w_streak_full);

    assign if_ready = w_if_grant;
    assign dm_ready = w_dm_grant;

    // Counts data grants that overtook a waiting fetch. Any cycle without a
    // pending fetch, or a fetch grant, restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (!if_req || w_if_grant) begin
            r_streak <= '0;
        end else if (w_dm_grant && !w_streak_full) begin
            r_streak <= r_streak + c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Memory command register
    // ------------------------------------------------------------------
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Idle cycles drop only the enable; the rest of the command holds so the
    // bus does not toggle needlessly. Fetches never alter the write data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_dm_grant) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
        end else if (w_if_grant) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
        end else begin
            r_mem_en    <= 1'b0;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    tag_t w_issue_tag;
    tag_t w_ret_tag;

    always_comb begin
        w_issue_tag = TAG_NONE;
        if (w_dm_grant) begin
            w_issue_tag.owner   = OWN_DM;
            w_issue_tag.is_read = !dm_we;
        end else if (w_if_grant) begin
            w_issue_tag.owner   = OWN_IF;
            w_issue_tag.is_read = 1'b1;
        end
    end

    arb_tag_pipe u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .issue_tag (w_issue_tag),
        .ret_tag   (w_ret_tag)
    );

    // Responses are suppressed while reset is asserted so nothing issued
    // before the reset can surface, even in the reset cycle itself.
    assign if_rvalid = !reset && (w_ret_tag.owner == OWN_IF) &&
                       w_ret_tag.is_read && !w_ret_tag.killed;
    assign dm_rvalid = !reset && (w_ret_tag.owner == OWN_DM) && w_ret_tag.is_read;

    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. Directed stimulus
//               pushes the expected (return cycle, data) of every read that
//               should respond; a negedge monitor pops and compares whenever
//               a response port asserts rvalid, and flags responses that are
//               missing or unexpected. A small synchronous memory model
//               sits on the mem_* port; its contents follow pat(addr).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int   ADDR_W = 32;
    localparam int   DATA_W = 32;
    localparam logic L      = 1'b0;
    localparam logic H      = 1'b1;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // Synchronous single-port memory, 256 words.
    logic [31:0] mem_model [0:255];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = pat(32'(i) << 2);
        end
    end

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) mem_model[mem_addr[9:2]] <= mem_wdata;
            else                 mem_rdata <= mem_model[mem_addr[9:2]];
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    exp_t e_if;
    exp_t e_dm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (if_rvalid === 1'b1) begin
            if (if_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL if_rvalid_extra@%0d: got data %h expected no response", cyc, if_rdata);
            end else begin
                e_if = if_q.pop_front();
                check($sformatf("if_ret_cycle@%0d", cyc), cyc, e_if.cyc);
                check($sformatf("if_rdata@%0d", cyc), if_rdata, e_if.data);
            end
        end else if (if_q.size() != 0 && if_q[0].cyc <= cyc) begin
            e_if = if_q.pop_front();
            checks++; errors++;
            $display("FAIL if_rvalid_missing@%0d: got none expected data %h", cyc, e_if.data);
        end

        if (dm_rvalid === 1'b1) begin
            if (dm_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dm_rvalid_extra@%0d: got data %h expected no response", cyc, dm_rdata);
            end else begin
                e_dm = dm_q.pop_front();
                check($sformatf("dm_ret_cycle@%0d", cyc), cyc, e_dm.cyc);
                check($sformatf("dm_rdata@%0d", cyc), dm_rdata, e_dm.data);
            end
        end else if (dm_q.size() != 0 && dm_q[0].cyc <= cyc) begin
            e_dm = dm_q.pop_front();
            checks++; errors++;
            $display("FAIL dm_rvalid_missing@%0d: got none expected data %h", cyc, e_dm.data);
        end
    end

    // ---------------- stimulus ----------------
    // One cycle: drive inputs, check the expected grant, and record the
    // response expected two cycles later.
    task automatic step(input logic rst_v, input logic fl,
                        input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic exp_ir, input logic exp_dr,
                        input logic push_if, input logic push_dm,
                        input logic [31:0] ed);
        @(posedge clk);
        #1;
        reset    = rst_v;
        flush    = fl;
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dd;
        @(negedge clk);
        check($sformatf("if_ready@%0d", cyc), {31'b0, if_ready}, {31'b0, exp_ir});
        check($sformatf("dm_ready@%0d", cyc), {31'b0, dm_ready}, {31'b0, exp_dr});
        if (push_if) if_q.push_back('{cyc + 2, ed});
        if (push_dm) dm_q.push_back('{cyc + 2, ed});
    endtask

    task automatic idle();
        step(L, L, L, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;

        // Reset with both requests pending: no grants
        step(H, L, H, 32'h0, H, L, 32'h10, 32'h0, L, L, L, L, 32'h0);
        step(H, L, H, 32'h0, H, L, 32'h10, 32'h0, L, L, L, L, 32'h0);
        check("mem_en_in_reset", {31'b0, mem_en}, 32'h0);
        check("mem_addr_in_reset", mem_addr, 32'h0);

        // Contention: D,D,D,D,I,D,D,D (first cycle after reset goes to data)
        for (int i = 0; i < 8; i++) begin
            if (i == 4) step(L, L, H, 32'h0, H, L, 32'h10, 32'h0, H, L, H, L, pat(32'h0));
            else        step(L, L, H, 32'h0, H, L, 32'h10, 32'h0, L, H, L, H, pat(32'h10));
        end
        idle();

        // Fetch only, back to back
        step(L, L, H, 32'h0, L, L, 32'h0, 32'h0, H, L, H, L, pat(32'h0));
        step(L, L, H, 32'h4, L, L, 32'h0, 32'h0, H, L, H, L, pat(32'h4));
        step(L, L, H, 32'h8, L, L, 32'h0, 32'h0, H, L, H, L, pat(32'h8));
        idle();
        idle();

        // Store then load to the same address
        step(L, L, L, 32'h0, H, H, 32'h40, 32'hDEAD_BEEF, L, H, L, L, 32'h0);
        step(L, L, L, 32'h0, H, L, 32'h40, 32'h0, L, H, L, H, 32'hDEAD_BEEF);
        idle();
        idle();

        // Flush: fetches in c1..c3, flush in c3, new fetch in c4 survives
        step(L, L, H, 32'h10, L, L, 32'h0, 32'h0, H, L, L, L, 32'h0);
        step(L, L, H, 32'h14, L, L, 32'h0, 32'h0, H, L, L, L, 32'h0);
        step(L, H, H, 32'h18, L, L, 32'h0, 32'h0, H, L, L, L, 32'h0);
        step(L, L, H, 32'h1C, L, L, 32'h0, 32'h0, H, L, H, L, pat(32'h1C));
        idle();
        idle();
        idle();

        // Mixed flush: load survives, fetch issued with the flush dies
        step(L, L, L, 32'h0, H, L, 32'h20, 32'h0, L, H, L, H, pat(32'h20));
        step(L, H, H, 32'h24, L, L, 32'h0, 32'h0, H, L, L, L, 32'h0);
        idle();
        idle();

        // Reset mid-operation: reads in c1, c2 never return
        step(L, L, H, 32'h8, L, L, 32'h0, 32'h0, H, L, L, L, 32'h0);
        step(L, L, L, 32'h0, H, L, 32'h4, 32'h5555_AAAA, L, H, L, L, 32'h0);
        step(H, L, H, 32'hC, H, L, 32'h8, 32'h0, L, L, L, L, 32'h0);
        idle();
        check("post_reset_mem_en", {31'b0, mem_en}, 32'h0);
        check("post_reset_mem_we", {31'b0, mem_we}, 32'h0);
        check("post_reset_mem_addr", mem_addr, 32'h0);
        check("post_reset_mem_wdata", mem_wdata, 32'h0);
        check("post_reset_if_rvalid", {31'b0, if_rvalid}, 32'h0);
        check("post_reset_dm_rvalid", {31'b0, dm_rvalid}, 32'h0);
        idle();
        idle();
        idle();

        check("if_queue_drained", if_q.size(), 32'h0);
        check("dm_queue_drained", dm_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
